// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32IM multi-cycle control unit: opcodes, FSM states
// and the select codes driven onto the datapath.
package rv_ctrl_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MDWAIT, MEM, WB, TRAP
    } state_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_MD  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_RF  = 2'b10;
    localparam logic [1:0] ALU_IF  = 2'b11;

    function automatic logic op_valid(input logic [4:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_valid = 1'b1;
            default:                          op_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_ctrl_wdog.sv
// Memory-wait watchdog: counts cycles spent waiting for a ready handshake and
// flags a timeout on the last tolerated cycle unless ready arrives in it.
module rv_ctrl_wdog #(
    parameter int WDOG_W   = 4,
    parameter int WDOG_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    localparam logic [WDOG_W-1:0] MAX_CNT = WDOG_W'(WDOG_MAX);

    logic [WDOG_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (active && !ready)
            count <= count + WDOG_W'(1);
    end

    // A timeout always forces a state change, so count never passes MAX_CNT.
    assign timeout = active && !ready && (count == MAX_CNT);

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32IM control FSM (fetch/decode/exec/mem/wb) with watchdog and
// sticky error flags. Define RV_C_EN to accept pre-expanded compressed instructions.
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 2,
    parameter int WDOG_W   = 4,
    parameter int WDOG_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               md_done,
    input  logic               br_taken,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         mem_to_reg,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src,
    output logic               reg_write,
    output logic               md_start,
`ifdef RV_C_EN
    output logic               pc_inc2,
`endif
    output logic               illegal,
    output logic               bus_err
);

    state_t state, next_state;
    logic   illegal_set, bus_err_set;
    logic   wd_active, wd_ready, wd_timeout;

    logic [4:0] opcode;
    logic       is_load, is_md, inst_ok;
    logic       unused_inst;

    assign opcode      = inst[6:2];
    assign is_load     = (opcode == OP_LOAD);
    assign is_md       = (opcode == OP_R) && (inst[31:25] == F7_MULDIV);
    assign unused_inst = ^inst[24:7];

`ifdef RV_C_EN
    assign inst_ok = op_valid(opcode);
`else
    assign inst_ok = op_valid(opcode) && (inst[1:0] == 2'b11);
`endif

    assign wd_active = (state == FETCH) || (state == MEM);
    assign wd_ready  = (state == FETCH) ? imem_ready : dmem_ready;

    rv_ctrl_wdog #(
        .WDOG_W   (WDOG_W),
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .ready   (wd_ready),
        .clear   (next_state != state),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= next_state;
            if (illegal_set) illegal <= 1'b1;
            if (bus_err_set) bus_err <= 1'b1;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        illegal_set = 1'b0;
        bus_err_set = 1'b0;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        branch      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = WB_ALU;
        alu_op      = ALUOP_W'(ALU_ADD);
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        md_start    = 1'b0;

        case (state)
            IDLE: next_state = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    next_state = DECODE;
                end else if (wd_timeout) begin
                    bus_err_set = 1'b1;
                    next_state  = TRAP;
                end
            end

            DECODE: begin
                if (inst_ok) begin
                    next_state = EXEC;
                end else begin
                    illegal_set = 1'b1;
                    next_state  = TRAP;
                end
            end

            EXEC: begin
                next_state = WB;
                case (opcode)
                    OP_R: begin
                        alu_op = ALUOP_W'(ALU_RF);
                        if (is_md) begin
                            md_start   = 1'b1;
                            next_state = MDWAIT;
                        end
                    end
                    OP_IMM: begin
                        alu_op  = ALUOP_W'(ALU_IF);
                        alu_src = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src    = 1'b1;
                        next_state = MEM;
                    end
                    OP_BRANCH: begin
                        branch     = 1'b1;
                        alu_op     = ALUOP_W'(ALU_BR);
                        pc_write   = 1'b1;
                        pc_src     = br_taken ? PC_IMM : PC_PLUS4;
                        next_state = FETCH;
                    end
                    OP_JALR, OP_LUI, OP_AUIPC: alu_src = 1'b1;
                    default: ;
                endcase
            end

            MDWAIT: if (md_done) next_state = WB;

            MEM: begin
                mem_read  = is_load;
                mem_write = !is_load;
                if (dmem_ready) begin
                    if (is_load) begin
                        next_state = WB;
                    end else begin
                        pc_write   = 1'b1;
                        next_state = FETCH;
                    end
                end else if (wd_timeout) begin
                    bus_err_set = 1'b1;
                    next_state  = TRAP;
                end
            end

            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                next_state = FETCH;
                if (is_load)
                    mem_to_reg = WB_MEM;
                else if (opcode == OP_JAL || opcode == OP_JALR)
                    mem_to_reg = WB_PC4;
                else if (is_md)
                    mem_to_reg = WB_MD;
                if (opcode == OP_JAL)
                    pc_src = PC_IMM;
                else if (opcode == OP_JALR)
                    pc_src = PC_ALU;
            end

            TRAP: ;

            default: next_state = IDLE;
        endcase
    end

`ifdef RV_C_EN
    logic is_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            is_c <= 1'b0;
        else if (state == DECODE)
            is_c <= (inst[1:0] != 2'b11);
    end

    assign pc_inc2 = is_c && pc_write && (pc_src == PC_PLUS4);
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed scoreboard bench for rv_mc_ctrl: each step queues the expected output
// vector for the current cycle, then pops and checks it before the next edge.
module tb_rv_mc_ctrl;

    localparam int WDOG_MAX = 15;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       md_start;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        imem_ready, dmem_ready, md_done, br_taken;
    logic        imem_req, ir_write, pc_write, branch, mem_read, mem_write;
    logic        alu_src, reg_write, md_start, illegal, bus_err;
    logic [1:0]  pc_src, mem_to_reg, alu_op;
`ifdef RV_C_EN
    logic        pc_inc2;
`endif

    outs_t obs;
    assign obs = {imem_req, ir_write, pc_write, pc_src, branch, mem_read, mem_write,
                  mem_to_reg, alu_op, alu_src, reg_write, md_start, illegal, bus_err};

    always #5 clk = ~clk;

    rv_mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .md_done    (md_done),
        .br_taken   (br_taken),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .md_start   (md_start),
`ifdef RV_C_EN
        .pc_inc2    (pc_inc2),
`endif
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    string tag_q[$];
    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  sticky_ill = 1'b0;
    logic  sticky_bus = 1'b0;

    function automatic outs_t o_zero();
        outs_t e = '0;
        return e;
    endfunction

    function automatic outs_t o_fetch(input logic rdy);
        outs_t e = '0;
        e.imem_req = 1'b1;
        e.ir_write = rdy;
        return e;
    endfunction

    function automatic outs_t o_alu(input logic [1:0] op, input logic src);
        outs_t e = '0;
        e.alu_op  = op;
        e.alu_src = src;
        return e;
    endfunction

    function automatic outs_t o_wb(input logic [1:0] m2r, input logic [1:0] psrc);
        outs_t e = '0;
        e.reg_write  = 1'b1;
        e.pc_write   = 1'b1;
        e.mem_to_reg = m2r;
        e.pc_src     = psrc;
        return e;
    endfunction

    function automatic outs_t o_br(input logic [1:0] psrc);
        outs_t e = '0;
        e.branch   = 1'b1;
        e.alu_op   = 2'b01;
        e.pc_write = 1'b1;
        e.pc_src   = psrc;
        return e;
    endfunction

    // Inputs are set at the falling edge; outputs are checked 1 unit later.
    task automatic step(input string tag, input outs_t e);
        outs_t x;
        string t;
        e.illegal = sticky_ill;
        e.bus_err = sticky_bus;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        #1;
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        checks++;
        assert (obs === x) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, x);
        end
        @(negedge clk);
    endtask

    task automatic fetch_decode(input logic [31:0] i, input int waits);
        inst       = i;
        imem_ready = 1'b0;
        for (int k = 0; k < waits; k++) step("fetch_wait", o_fetch(1'b0));
        imem_ready = 1'b1;
        step("fetch", o_fetch(1'b1));
        imem_ready = 1'b0;
        step("decode", o_zero());
    endtask

    initial begin
        outs_t e;
        rst = 1'b1; inst = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0; md_done = 1'b0; br_taken = 1'b0;
        #1;
        step("reset", o_zero());
        rst = 1'b0;
        step("idle", o_zero());

        // ADD: FETCH, DECODE, EXEC, WB
        fetch_decode(32'h002081B3, 0);
        step("add_exec", o_alu(2'b10, 1'b0));
        step("add_wb", o_wb(2'b00, 2'b00));

        // ADDI with imem_ready arriving on the last tolerated wait cycle
        fetch_decode(32'h00108093, WDOG_MAX);
        step("addi_exec", o_alu(2'b11, 1'b1));
        step("addi_wb", o_wb(2'b00, 2'b00));

        // LW with dmem_ready delayed 3 cycles
        fetch_decode(32'h0000A183, 0);
        step("lw_exec", o_alu(2'b00, 1'b1));
        e = o_zero(); e.mem_read = 1'b1;
        for (int k = 0; k < 3; k++) step("lw_mem_wait", e);
        dmem_ready = 1'b1;
        step("lw_mem_done", e);
        dmem_ready = 1'b0;
        step("lw_wb", o_wb(2'b01, 2'b00));

        // SW: MEM completes straight back to FETCH
        fetch_decode(32'h0030A023, 0);
        step("sw_exec", o_alu(2'b00, 1'b1));
        dmem_ready = 1'b1;
        e = o_zero(); e.mem_write = 1'b1; e.pc_write = 1'b1;
        step("sw_mem", e);
        dmem_ready = 1'b0;

        // BEQ taken then not taken
        fetch_decode(32'h00208463, 0);
        br_taken = 1'b1;
        step("beq_taken", o_br(2'b01));
        br_taken = 1'b0;
        fetch_decode(32'h00208463, 0);
        step("beq_not_taken", o_br(2'b00));

        // MUL with md_done after 5 cycles
        fetch_decode(32'h022081B3, 0);
        e = o_alu(2'b10, 1'b0); e.md_start = 1'b1;
        step("mul_exec", e);
        for (int k = 0; k < 4; k++) step("mul_wait", o_zero());
        md_done = 1'b1;
        step("mul_done", o_zero());
        md_done = 1'b0;
        step("mul_wb", o_wb(2'b11, 2'b00));

        // JAL, JALR, LUI writeback selects
        fetch_decode(32'h008000EF, 0);
        step("jal_exec", o_zero());
        step("jal_wb", o_wb(2'b10, 2'b01));
        fetch_decode(32'h000080E7, 0);
        step("jalr_exec", o_alu(2'b00, 1'b1));
        step("jalr_wb", o_wb(2'b10, 2'b10));
        fetch_decode(32'h123450B7, 0);
        step("lui_exec", o_alu(2'b00, 1'b1));
        step("lui_wb", o_wb(2'b00, 2'b00));

        // rst pulse mid-MEM drops the request immediately
        fetch_decode(32'h0000A183, 0);
        step("lw2_exec", o_alu(2'b00, 1'b1));
        e = o_zero(); e.mem_read = 1'b1;
        step("lw2_mem", e);
        rst = 1'b1;
        step("rst_mid_mem", o_zero());
        rst = 1'b0;
        step("idle_after_rst", o_zero());

        // imem_ready stuck low: WDOG_MAX+1 fetch cycles then TRAP with bus_err
        for (int k = 0; k <= WDOG_MAX; k++) step("fetch_stuck", o_fetch(1'b0));
        sticky_bus = 1'b1;
        step("trap_bus_err", o_zero());
        imem_ready = 1'b1;
        step("trap_bus_err_sticky", o_zero());
        imem_ready = 1'b0;
        rst = 1'b1; sticky_bus = 1'b0;
        step("rst_clears_bus_err", o_zero());
        rst = 1'b0;
        step("idle2", o_zero());

        // Illegal opcode traps and stays flagged until rst
        fetch_decode(32'h0000007F, 0);
        sticky_ill = 1'b1;
        for (int k = 0; k < 3; k++) step("trap_illegal", o_zero());
        rst = 1'b1; sticky_ill = 1'b0;
        step("rst_clears_illegal", o_zero());
        rst = 1'b0;
        step("idle3", o_zero());

`ifndef RV_C_EN
        // Valid opcode but inst[1:0] != 11 is illegal in the base build
        fetch_decode(32'h002081B2, 0);
        sticky_ill = 1'b1;
        step("trap_low_bits", o_zero());
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
